// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: register-file geometry, named indices and reset values.
// Imported by the integer register file and its write-back demultiplexer.
package riscv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NREGS      = 32;

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 2;

   localparam logic [XLEN-1:0] SP_INIT_DEFAULT = 32'h0000_0FFC;

   // Reset value of architectural register idx: only the stack pointer is non-zero.
   function automatic logic [XLEN-1:0] reg_reset_value(input int idx,
                                                       input logic [XLEN-1:0] sp_init);
      reg_reset_value = (idx == REG_SP) ? sp_init : '0;
   endfunction

endpackage

// File: rtl/wb_demux.sv
// Write-back demux: rd_addr + wr_en to a one-hot register write-enable vector, x0 masked.
// Combinational, zero latency; no backpressure (at most one enable per cycle).
module wb_demux
   import riscv_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic                  wr_en,
   output logic [NREGS-1:0]      wr_sel
);

   always_comb begin
      wr_sel = '0;
      if (wr_en) begin
         wr_sel[rd_addr] = 1'b1;
      end
      // x0 is hardwired to zero, so it never receives a write strobe.
      wr_sel[REG_ZERO] = 1'b0;
   end

endmodule

// File: rtl/reg_file_wb.sv
// RV32I integer register file: one write port, two bypassable read ports, one debug read port.
// Writes land on the next clk edge, reads are combinational; no backpressure or stalls.
module reg_file_wb
   import riscv_pkg::*;
#(
   parameter int              XLEN    = riscv_pkg::XLEN,
   parameter int              NREGS   = riscv_pkg::NREGS,
   parameter bit              BYPASS  = 1'b1,
   parameter logic [XLEN-1:0] SP_INIT = SP_INIT_DEFAULT
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      rs1_addr,
   input  logic [4:0]      rs2_addr,
   input  logic [4:0]      rd_addr,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_data,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      dbg_addr,
   output logic [XLEN-1:0] dbg_data
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] wr_sel;
   logic             byp1;
   logic             byp2;

   wb_demux u_wb_demux (
      .rd_addr (rd_addr),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel)
   );

   // Reset outranks any write presented on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= reg_reset_value(i, SP_INIT);
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            if (wr_sel[i]) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   // wr_sel already excludes x0, so a hit implies a real, non-zero destination.
   always_comb begin
      byp1 = BYPASS && !rst && wr_sel[rs1_addr];
      byp2 = BYPASS && !rst && wr_sel[rs2_addr];
   end

   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      dbg_data = '0;
      if (rs1_addr != 5'(REG_ZERO)) begin
         rs1_data = byp1 ? wr_data : regs[rs1_addr];
      end
      if (rs2_addr != 5'(REG_ZERO)) begin
         rs2_data = byp2 ? wr_data : regs[rs2_addr];
      end
      if (dbg_addr != 5'(REG_ZERO)) begin
         dbg_data = regs[dbg_addr];
      end
   end

endmodule
